avg_pool_stream: RTL and testbench

AVG_POOL_STREAM -- requirements
Module: avg_pool_stream

---
 rtl/avg_pool_stream.sv | 193 +++++++++++++++++++
 tb/tb_avg_pool_stream.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_pool_stream.sv
// Streaming 2x2 FP16 pooling over channel-major frames; define AVG_POOL_MAX_EN to add
// a pool_mode input that selects 2x2 max (1) instead of average (0).

module AvgPoolUnit (
  input  logic [15:0] numA,
  input  logic [15:0] numB,
  input  logic [15:0] numC,
  input  logic [15:0] numD,
  output logic [15:0] result
);

  // Every finite FP16 value is an exact multiple of 2^-24 below 2^16, so the four-way
  // sum is exact in fixed point and only the final sum/4 is rounded (nearest-even).
  function automatic logic signed [42:0] toFixed(input logic [15:0] num);
    logic [4:0]  expField;
    logic [10:0] mant;
    logic [39:0] mag;
    expField = num[14:10];
    mant     = (expField == 5'd0) ? {1'b0, num[9:0]} : {1'b1, num[9:0]};
    mag      = {29'd0, mant} << ((expField == 5'd0) ? 5'd0 : expField - 5'd1);
    toFixed  = num[15] ? -$signed({3'b000, mag}) : $signed({3'b000, mag});
  endfunction

  logic signed [42:0] sum;
  logic [41:0] mag;
  logic [5:0]  lead;
  logic [5:0]  shift;
  logic [10:0] kept;
  logic [4:0]  base;
  logic        guard;
  logic        sticky;
  logic        roundUp;
  logic [14:0] magBits;

  // mag has its LSB at 2^-26, i.e. it already is the sum divided by four.
  always_comb begin
    sum  = toFixed(numA) + toFixed(numB) + toFixed(numC) + toFixed(numD);
    mag  = sum[42] ? 42'(-sum) : sum[41:0];
    lead = 6'd0;
    for (int i = 0; i < 42; i++) begin
      if (mag[i]) lead = 6'(i);
    end
    shift   = (lead >= 6'd12) ? lead - 6'd10 : 6'd2;
    kept    = 11'(mag >> shift);
    guard   = mag[shift - 6'd1];
    sticky  = |(mag & ~({42{1'b1}} << (shift - 6'd1)));
    roundUp = guard && (sticky || kept[0]);
    base    = (lead >= 6'd12) ? 5'(lead - 6'd12) : 5'd0;
    // The hidden bit in kept bumps the exponent, and a rounding carry ripples into it.
    magBits = {base, 10'd0} + {4'd0, kept} + {14'd0, roundUp};
    result  = (magBits == 15'd0) ? 16'h0000 : {sum[42], magBits};
  end

endmodule

module avg_pool_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int Depth      = 16,
  parameter int inputH     = 10,
  parameter int inputW     = 10
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef AVG_POOL_MAX_EN
  input  logic                  pool_mode,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int ColW = (inputW > 1) ? $clog2(inputW) : 1;
  localparam int RowW = (inputH > 1) ? $clog2(inputH) : 1;
  localparam int ChW  = (Depth > 1) ? $clog2(Depth) : 1;

  logic [ColW-1:0]       colCount_q, colCount_d;
  logic [RowW-1:0]       rowCount_q, rowCount_d;
  logic [ChW-1:0]        chCount_q, chCount_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] outData_q, outData_d;
  logic                  outValid_q, outValid_d;
  logic                  outLast_q, outLast_d;
  logic [DATA_WIDTH-1:0] lineBuf_q [inputW];

  logic inHs, colEnd, rowEnd, chEnd, windowDone, frameEnd;
  logic [ColW-1:0]       prevCol;
  logic [DATA_WIDTH-1:0] avgResult, poolResult;

  assign in_ready   = !outValid_q || out_ready;
  assign inHs       = in_valid && in_ready;
  assign colEnd     = (colCount_q == ColW'(inputW - 1));
  assign rowEnd     = (rowCount_q == RowW'(inputH - 1));
  assign chEnd      = (chCount_q == ChW'(Depth - 1));
  assign windowDone = inHs && rowCount_q[0] && colCount_q[0];
  assign frameEnd   = chEnd && rowEnd && colEnd;
  assign prevCol    = colCount_q - ColW'(1);

  AvgPoolUnit avgUnit (
    .numA   (lineBuf_q[prevCol]),
    .numB   (lineBuf_q[colCount_q]),
    .numC   (hold_q),
    .numD   (in_data),
    .result (avgResult)
  );

`ifdef AVG_POOL_MAX_EN
  // Ordering key: negatives flip their magnitude so a plain unsigned compare works,
  // and -0 maps onto +0 so the two compare as a tie.
  function automatic logic [15:0] orderKey(input logic [15:0] num);
    orderKey = (num[15] && (num[14:0] != 15'd0)) ? {1'b0, ~num[14:0]} : {1'b1, num[14:0]};
  endfunction

  logic [DATA_WIDTH-1:0] maxResult;

  always_comb begin
    maxResult = lineBuf_q[prevCol];
    if (orderKey(lineBuf_q[colCount_q]) > orderKey(maxResult)) maxResult = lineBuf_q[colCount_q];
    if (orderKey(hold_q) > orderKey(maxResult)) maxResult = hold_q;
    if (orderKey(in_data) > orderKey(maxResult)) maxResult = in_data;
  end

  assign poolResult = pool_mode ? maxResult : avgResult;
`else
  assign poolResult = avgResult;
`endif

  always_comb begin
    colCount_d = colCount_q;
    rowCount_d = rowCount_q;
    chCount_d  = chCount_q;
    hold_d     = hold_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    outLast_d  = outLast_q;
    if (inHs) begin
      if (!colEnd) begin
        colCount_d = colCount_q + ColW'(1);
      end else begin
        colCount_d = '0;
        if (!rowEnd) begin
          rowCount_d = rowCount_q + RowW'(1);
        end else begin
          rowCount_d = '0;
          chCount_d  = chEnd ? '0 : chCount_q + ChW'(1);
        end
      end
    end
    if (inHs && rowCount_q[0] && !colCount_q[0]) hold_d = in_data;
    // A fresh window result wins over draining, so a same-cycle reload keeps out_valid high.
    if (windowDone) begin
      outData_d  = poolResult;
      outValid_d = 1'b1;
      outLast_d  = frameEnd;
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
      outLast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      colCount_q <= '0;
      rowCount_q <= '0;
      chCount_q  <= '0;
      hold_q     <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
    end else begin
      colCount_q <= colCount_d;
      rowCount_q <= rowCount_d;
      chCount_q  <= chCount_d;
      hold_q     <= hold_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      outLast_q  <= outLast_d;
    end
  end

  // Even rows refill the whole line before the odd row reads it, so no clear is needed.
  always_ff @(posedge clk) begin
    if (inHs && !rowCount_q[0]) lineBuf_q[colCount_q] <= in_data;
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_last  = outLast_q;

endmodule

// File: tb/tb_avg_pool_stream.sv
// Randomized bench for avg_pool_stream: a real-arithmetic model of the 2x2 pooling
// rules feeds a scoreboard; a second tiny instance covers single-window frames.

module tb_avg_pool_stream;

  localparam int Depth         = 16;
  localparam int InH           = 10;
  localparam int InW           = 10;
  localparam int FrameSamples  = Depth * InH * InW;
  localparam int FrameOutputs  = FrameSamples / 4;
  localparam int CycleBudget   = 20000;
`ifdef AVG_POOL_MAX_EN
  localparam bit UseModes = 1'b1;
`else
  localparam bit UseModes = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mInValid, mInReady, mOutValid, mOutReady, mOutLast;
  logic [15:0] mInData, mOutData;
  logic        sInValid, sInReady, sOutValid, sOutReady, sOutLast;
  logic [15:0] sInData, sOutData;
`ifdef AVG_POOL_MAX_EN
  logic        mPoolMode, sPoolMode;
`endif

  avg_pool_stream #(.DATA_WIDTH(16), .Depth(Depth), .inputH(InH), .inputW(InW)) mainDut (
    .clk       (clk),
    .reset     (reset),
`ifdef AVG_POOL_MAX_EN
    .pool_mode (mPoolMode),
`endif
    .in_valid  (mInValid),
    .in_ready  (mInReady),
    .in_data   (mInData),
    .out_valid (mOutValid),
    .out_ready (mOutReady),
    .out_data  (mOutData),
    .out_last  (mOutLast)
  );

  avg_pool_stream #(.DATA_WIDTH(16), .Depth(1), .inputH(2), .inputW(2)) smallDut (
    .clk       (clk),
    .reset     (reset),
`ifdef AVG_POOL_MAX_EN
    .pool_mode (sPoolMode),
`endif
    .in_valid  (sInValid),
    .in_ready  (sInReady),
    .in_data   (sInData),
    .out_valid (sOutValid),
    .out_ready (sOutReady),
    .out_data  (sOutData),
    .out_last  (sOutLast)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
  } ExpT;

  ExpT         expQ[$];
  logic [15:0] sampleQ[$];
  logic        modeQ[$];
  logic [15:0] frameBuf [FrameSamples];
  logic        windowMode [FrameOutputs];
  int          checkCount = 0;
  int          passCount = 0;
  int          lastSeen = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16ToReal(input logic [15:0] h);
    int  e = int'(h[14:10]);
    int  m = int'(h[9:0]);
    real v;
    if (e == 0) v = real'(m) * pow2(-24);
    else v = real'(1024 + m) * pow2(e - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic int roundEven(input real q);
    real fl = $floor(q);
    int  i  = $rtoi(fl);
    real d  = q - fl;
    if (d > 0.5 || (d == 0.5 && (i % 2) == 1)) i++;
    return i;
  endfunction

  // Zero results are always reported as +0.
  function automatic logic [15:0] realToFp16(input real x);
    real         m = (x < 0.0) ? -x : x;
    int          e;
    int          mant;
    logic [15:0] bits;
    if (m < pow2(-14)) begin
      mant = roundEven(m * pow2(24));
      bits = 16'(mant);
    end else begin
      e = -14;
      while (m >= pow2(e + 1)) e++;
      mant = roundEven(m / pow2(e) * 1024.0);
      if (mant == 2048) begin
        e++;
        mant = 1024;
      end
      bits = 16'(((e + 15) << 10) | (mant - 1024));
    end
    if (bits != 16'd0 && x < 0.0) bits[15] = 1'b1;
    return bits;
  endfunction

  function automatic logic [15:0] avgModel(input logic [15:0] a, b, c, d);
    return realToFp16((fp16ToReal(a) + fp16ToReal(b) + fp16ToReal(c) + fp16ToReal(d)) / 4.0);
  endfunction

  function automatic logic [15:0] maxModel(input logic [15:0] a, b, c, d);
    logic [15:0] best = a;
    if (fp16ToReal(b) > fp16ToReal(best)) best = b;
    if (fp16ToReal(c) > fp16ToReal(best)) best = c;
    if (fp16ToReal(d) > fp16ToReal(best)) best = d;
    return best;
  endfunction

  function automatic logic [15:0] randomFp16();
    return {1'($urandom_range(1)), 5'($urandom_range(30)), 10'($urandom)};
  endfunction

  task automatic buildFrame(input bit ramp);
    for (int i = 0; i < FrameSamples; i++) frameBuf[i] = ramp ? 16'(16'h3C00 + i) : randomFp16();
    for (int w = 0; w < FrameOutputs; w++) windowMode[w] = UseModes && !ramp && ($urandom_range(1) == 1);
  endtask

  task automatic enqueueFrame();
    ExpT         e;
    logic [15:0] a, b, c, d;
    int          base, w;
    for (int ch = 0; ch < Depth; ch++)
      for (int r = 0; r < InH; r++)
        for (int col = 0; col < InW; col++) begin
          sampleQ.push_back(frameBuf[(ch * InH + r) * InW + col]);
          modeQ.push_back(windowMode[(ch * (InH / 2) + r / 2) * (InW / 2) + col / 2]);
        end
    for (int ch = 0; ch < Depth; ch++)
      for (int orow = 0; orow < InH / 2; orow++)
        for (int ocol = 0; ocol < InW / 2; ocol++) begin
          base = (ch * InH + 2 * orow) * InW + 2 * ocol;
          w    = (ch * (InH / 2) + orow) * (InW / 2) + ocol;
          a = frameBuf[base];
          b = frameBuf[base + 1];
          c = frameBuf[base + InW];
          d = frameBuf[base + InW + 1];
          e.data = windowMode[w] ? maxModel(a, b, c, d) : avgModel(a, b, c, d);
          e.last = (w == FrameOutputs - 1);
          expQ.push_back(e);
        end
  endtask

  task automatic applyStimulus(input int validPct, input int readyPct, input int abortAfter, input bit doStall);
    int          sent = 0;
    int          cycles = 0;
    int          stallLeft = 0;
    bit          stallDone = 1'b0;
    logic [15:0] heldData = '0;
    logic        heldLast = 1'b0;
    ExpT         e;
    while ((sampleQ.size() > 0 || expQ.size() > 0) && cycles < CycleBudget) begin
      @(negedge clk);
      cycles++;
      mInValid = (sampleQ.size() > 0) && ($urandom_range(99) < validPct);
      mInData  = mInValid ? sampleQ[0] : 16'($urandom);
`ifdef AVG_POOL_MAX_EN
      mPoolMode = mInValid ? modeQ[0] : 1'($urandom_range(1));
`endif
      mOutReady = ($urandom_range(99) < readyPct);
      if (doStall && !stallDone && mOutValid && sent > 200) begin
        stallLeft = 5;
        stallDone = 1'b1;
        heldData  = mOutData;
        heldLast  = mOutLast;
      end
      if (stallLeft > 0) mOutReady = 1'b0;
      #1;
      if (stallLeft > 0) begin
        checkOutput("stall_in_ready", mInReady, 0);
        checkOutput("stall_out_valid", mOutValid, 1);
        checkOutput("stall_out_data", mOutData, heldData);
        checkOutput("stall_out_last", mOutLast, heldLast);
        stallLeft--;
      end
      if (mOutValid && mOutReady) begin
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("out_data", mOutData, e.data);
          checkOutput("out_last", mOutLast, e.last);
          if (mOutLast) lastSeen++;
        end else begin
          checkOutput("spurious_out", 32'(expQ.size()), 32'd1);
        end
      end
      if (mInValid && mInReady) begin
        void'(sampleQ.pop_front());
        void'(modeQ.pop_front());
        sent++;
        if (sent == abortAfter) break;
      end
    end
    if (abortAfter == 0) begin
      checkOutput("inputs_left", 32'(sampleQ.size()), 32'd0);
      checkOutput("outputs_left", 32'(expQ.size()), 32'd0);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset     = 1'b1;
    mInValid  = 1'b0;
    sInValid  = 1'b0;
    mOutReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", mOutValid, 0);
    checkOutput("reset_out_last", mOutLast, 0);
    checkOutput("reset_out_data", mOutData, 0);
    checkOutput("reset_small_valid", sOutValid, 0);
    reset     = 1'b0;
    mOutReady = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", mInReady, 1);
  endtask

  task automatic applySmallWindow(input logic [15:0] a, b, c, d, input bit maxMode,
                                  input logic [15:0] expected, input string tag);
    logic [15:0] win [4];
    win = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sInValid  = 1'b1;
      sInData   = win[i];
      sOutReady = 1'b1;
`ifdef AVG_POOL_MAX_EN
      sPoolMode = maxMode;
`endif
      #1;
      if (i == 3) checkOutput({tag, "_early_valid"}, sOutValid, 0);
    end
    @(negedge clk);
    sInValid = 1'b0;
    #1;
    checkOutput({tag, "_valid"}, sOutValid, 1);
    checkOutput({tag, "_data"}, sOutData, expected);
    checkOutput({tag, "_last"}, sOutLast, 1);
  endtask

  initial begin
    logic [15:0] a, b, c, d;
    reset     = 1'b1;
    mInValid  = 1'b0;
    mInData   = '0;
    mOutReady = 1'b0;
    sInValid  = 1'b0;
    sInData   = '0;
    sOutReady = 1'b1;
`ifdef AVG_POOL_MAX_EN
    mPoolMode = 1'b0;
    sPoolMode = 1'b0;
`endif
    doReset();

    applySmallWindow(16'h3C00, 16'h4000, 16'h4200, 16'h4400, 1'b0, 16'h4100, "small_avg");
`ifdef AVG_POOL_MAX_EN
    applySmallWindow(16'hBC00, 16'hC000, 16'hC200, 16'hC400, 1'b1, 16'hBC00, "small_max_neg");
    applySmallWindow(16'h3C00, 16'h4400, 16'h4000, 16'h4200, 1'b1, 16'h4400, "small_max_pos");
`endif
    for (int k = 0; k < 6; k++) begin
      a = randomFp16();
      b = randomFp16();
      c = randomFp16();
      d = randomFp16();
      applySmallWindow(a, b, c, d, 1'b0, avgModel(a, b, c, d), "small_rand");
    end

    $display("[TB] ramp frame at full rate");
    buildFrame(1'b1);
    enqueueFrame();
    applyStimulus(100, 100, 0, 1'b0);

    $display("[TB] random frame with a five-cycle output stall");
    buildFrame(1'b0);
    enqueueFrame();
    applyStimulus(70, 60, 0, 1'b1);

    $display("[TB] reset after 37 handshakes, then the same frame again");
    buildFrame(1'b0);
    enqueueFrame();
    applyStimulus(100, 50, 37, 1'b0);
    doReset();
    expQ.delete();
    sampleQ.delete();
    modeQ.delete();
    enqueueFrame();
    applyStimulus(80, 80, 0, 1'b0);

    $display("[TB] two back-to-back random frames");
    buildFrame(1'b0);
    enqueueFrame();
    buildFrame(1'b0);
    enqueueFrame();
    applyStimulus(75, 65, 0, 1'b0);

    checkOutput("last_count", 32'(lastSeen), 32'd5);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
